// File: rtl/data_memory_responder.sv
`timescale 1ns/1ps
// Data-port memory responder: valid/ready request and response handshakes, fixed
// access latency, byte-enable stores, and misaligned/out-of-range error reporting.
module data_memory_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_error
);

   localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic        resp_valid_q, resp_error_q;
   logic [31:0] resp_rdata_q;
   logic        write_q;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  be_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic             acc_d, acc_write_d, acc_err_d;
   logic [31:0]      acc_addr_d, acc_wdata_d, off_d, word_off_d, rd_word_d;
   logic [3:0]       acc_be_d;
   logic [IDX_W-1:0] idx_d;

   // With LATENCY==1 the access happens on the accept edge, so it uses the live inputs.
   always_comb begin
      if (state_q == S_IDLE) begin
         acc_write_d = req_write;
         acc_addr_d  = req_addr;
         acc_wdata_d = req_wdata;
         acc_be_d    = req_be;
      end else begin
         acc_write_d = write_q;
         acc_addr_d  = addr_q;
         acc_wdata_d = wdata_q;
         acc_be_d    = be_q;
      end
      acc_d      = !reset &&
                   (((state_q == S_IDLE) && req_valid && (LATENCY == 1)) ||
                    ((state_q == S_WAIT) && (cnt_q == 4'd1)));
      off_d      = acc_addr_d - BASE_ADDR;
      word_off_d = off_d >> 2;
      acc_err_d  = (acc_addr_d[1:0] != 2'b00) || (acc_addr_d < BASE_ADDR) ||
                   (word_off_d >= 32'(DEPTH_WORDS));
      idx_d      = word_off_d[IDX_W-1:0];
      rd_word_d  = acc_err_d ? '0 : mem[idx_d];
   end

   always_ff @(posedge clk) begin
      if (acc_d && acc_write_d && !acc_err_d) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (acc_be_d[b]) mem[idx_d][8*b +: 8] <= acc_wdata_d[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_error_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  write_q <= req_write;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  be_q    <= req_be;
                  if (!acc_d) begin
                     cnt_q   <= CNT_INIT;
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (!acc_d) cnt_q <= cnt_q - 4'd1;
            end
            S_RESP: begin
               if (resp_ready) begin
                  state_q      <= S_IDLE;
                  resp_valid_q <= 1'b0;
                  resp_rdata_q <= '0;
                  resp_error_q <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
         if (acc_d) begin
            state_q      <= S_RESP;
            cnt_q        <= '0;
            resp_valid_q <= 1'b1;
            resp_error_q <= acc_err_d;
            resp_rdata_q <= acc_write_d ? '0 : rd_word_d;
         end
      end
   end

   assign req_ready  = (state_q == S_IDLE) && !reset;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_error = resp_error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
`timescale 1ns/1ps
// Bench for data_memory_responder: three builds (LATENCY 2, 1, 15) checked with a
// directed vector table, randomized traffic against a word-array model, and a reset-abort sequence.
module tb_data_memory_responder;

   localparam int unsigned DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h1001_0000;
   localparam int          NI    = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid [NI];
   logic        req_ready [NI];
   logic        req_write [NI];
   logic [31:0] req_addr  [NI];
   logic [31:0] req_wdata [NI];
   logic [3:0]  req_be    [NI];
   logic        resp_valid[NI];
   logic        resp_ready[NI];
   logic [31:0] resp_rdata[NI];
   logic        resp_error[NI];

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mdl [NI][DEPTH];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      data_memory_responder #(
         .DEPTH_WORDS(DEPTH),
         .BASE_ADDR  (BASE),
         .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 1 : 15))
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_write (req_write[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .req_be    (req_be[g]),
         .resp_valid(resp_valid[g]),
         .resp_ready(resp_ready[g]),
         .resp_rdata(resp_rdata[g]),
         .resp_error(resp_error[g])
      );
   end

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      int          stall;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   function automatic int lat_of(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // packs {resp_valid, req_ready, resp_error, resp_rdata} for whole-output comparisons
   function automatic logic [63:0] outs(input int g);
      return {29'd0, resp_valid[g], req_ready[g], resp_error[g], resp_rdata[g]};
   endfunction

   function automatic logic [63:0] exp_outs(input logic v, input logic r, input logic e,
                                            input logic [31:0] d);
      return {29'd0, v, r, e, d};
   endfunction

   // One complete transaction; request inputs are scrambled right after acceptance.
   task automatic txn(input int g, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input int stall, input logic [31:0] exp_rd,
                      input logic exp_err, input string tag);
      int n;
      @(negedge clk);
      n = 0;
      while (!req_ready[g] && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, " req_ready_idle"}, 64'(req_ready[g]), 64'd1);
      req_valid[g] = 1'b1;
      req_write[g] = w;
      req_addr[g]  = a;
      req_wdata[g] = d;
      req_be[g]    = be;
      @(posedge clk);
      #1;
      req_valid[g] = 1'b0;
      req_write[g] = 1'($urandom);
      req_addr[g]  = $urandom;
      req_wdata[g] = $urandom;
      req_be[g]    = 4'($urandom);
      n = 0;
      while (n < lat_of(g) + 3) begin
         @(negedge clk);
         n++;
         if (n == 1) check({tag, " req_ready_busy"}, 64'(req_ready[g]), 64'd0);
         if (resp_valid[g]) break;
      end
      check({tag, " latency"}, 64'(n), 64'(lat_of(g)));
      if (!resp_valid[g]) return;
      check({tag, " rdata"}, 64'(resp_rdata[g]), 64'(exp_rd));
      check({tag, " error"}, 64'(resp_error[g]), 64'(exp_err));
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check({tag, " stall_hold"}, outs(g), exp_outs(1'b1, 1'b0, exp_err, exp_rd));
      end
      resp_ready[g] = 1'b1;
      @(posedge clk);
      #1;
      resp_ready[g] = 1'b0;
      @(negedge clk);
      check({tag, " after_resp"}, outs(g), exp_outs(1'b0, 1'b1, 1'b0, 32'h0));
   endtask

   function automatic logic m_err(input logic [31:0] a);
      longint la;
      la = longint'(a);
      return (la % 4 != 0) || (la < longint'(BASE)) || (la >= longint'(BASE) + 4 * longint'(DEPTH));
   endfunction

   function automatic logic [31:0] rand_addr();
      int unsigned i;
      int unsigned k;
      logic [31:0] w;
      i = $urandom_range(0, 19);
      w = BASE + 4 * ((i < 16) ? i : (DEPTH - 20 + i));
      k = $urandom_range(0, 7);
      if (k == 5) return w + 32'($urandom_range(1, 3));
      if (k == 6) begin
         case ($urandom_range(0, 3))
            0:       return BASE - 32'd4;
            1:       return BASE + 4 * DEPTH;
            2:       return 32'hFFFF_FFFC;
            default: return BASE + 4 * DEPTH + 32'd4;
         endcase
      end
      if (k == 7) return $urandom | 32'h8000_0000;
      return w;
   endfunction

   task automatic model_txn(input int g, input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be, input int stall, input string tag);
      logic        e;
      logic [31:0] rd;
      int unsigned wi;
      e  = m_err(a);
      wi = (a - BASE) / 4;
      rd = (e || w) ? 32'h0 : mdl[g][wi];
      txn(g, w, a, d, be, stall, rd, e, tag);
      if (w && !e) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mdl[g][wi][8*b +: 8] = d[8*b +: 8];
         end
      end
   endtask

   vec_t tbl[$];

   initial begin
      reset = 1'b1;
      for (int g = 0; g < NI; g++) begin
         req_valid[g] = 1'b0; req_write[g] = 1'b0; req_addr[g] = '0;
         req_wdata[g] = '0;   req_be[g]    = '0;   resp_ready[g] = 1'b0;
      end

      tbl.push_back('{1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         1'b0});
      tbl.push_back('{1'b0, 32'h1001_0004, 32'h0,         4'hF, 5, 32'hDEAD_BEEF, 1'b0});
      tbl.push_back('{1'b1, 32'h1001_0008, 32'h1122_3344, 4'hF, 0, 32'h0,         1'b0});
      tbl.push_back('{1'b1, 32'h1001_0008, 32'hAABB_CCDD, 4'h5, 0, 32'h0,         1'b0});
      tbl.push_back('{1'b0, 32'h1001_0008, 32'h0,         4'h0, 0, 32'h11BB_33DD, 1'b0});
      tbl.push_back('{1'b0, 32'h1001_0002, 32'h0,         4'hF, 5, 32'h0,         1'b1});
      tbl.push_back('{1'b1, 32'h1001_0FFC, 32'h5566_7788, 4'hF, 0, 32'h0,         1'b0});
      tbl.push_back('{1'b1, 32'h1001_1000, 32'hFFFF_FFFF, 4'hF, 0, 32'h0,         1'b1});
      tbl.push_back('{1'b0, 32'h1001_0FFC, 32'h0,         4'hF, 0, 32'h5566_7788, 1'b0});
      tbl.push_back('{1'b0, 32'h0FFF_FFFC, 32'h0,         4'hF, 0, 32'h0,         1'b1});
      tbl.push_back('{1'b1, 32'h1001_0004, 32'h0,         4'h0, 0, 32'h0,         1'b0});
      tbl.push_back('{1'b0, 32'h1001_0004, 32'h0,         4'hF, 0, 32'hDEAD_BEEF, 1'b0});
      tbl.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 0, 32'h0,         1'b1});

      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < NI; g++)
         check($sformatf("reset_outs%0d", g), outs(g), exp_outs(1'b0, 1'b0, 1'b0, 32'h0));
      reset = 1'b0;
      @(negedge clk);
      for (int g = 0; g < NI; g++)
         check($sformatf("post_reset%0d", g), outs(g), exp_outs(1'b0, 1'b1, 1'b0, 32'h0));

      foreach (tbl[i])
         txn(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, tbl[i].stall, tbl[i].rd, tbl[i].err,
             $sformatf("tbl%0d", i));

      for (int g = 0; g < NI; g++) begin
         for (int i = 0; i < 20; i++)
            model_txn(g, 1'b1, BASE + 4 * ((i < 16) ? i : (DEPTH - 20 + i)), $urandom, 4'hF, 0,
                      $sformatf("init%0d_%0d", g, i));
         for (int i = 0; i < 40; i++)
            model_txn(g, 1'($urandom), rand_addr(), $urandom, 4'($urandom),
                      $urandom_range(0, 2), $sformatf("rnd%0d_%0d", g, i));
      end

      // reset arrives on the access edge of a pending store; the store must be dropped
      txn(0, 1'b1, 32'h1001_000C, 32'h0, 4'hF, 0, 32'h0, 1'b0, "rst_pre");
      @(negedge clk);
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h1001_000C;
      req_wdata[0] = 32'h1234_5678; req_be[0] = 4'hF;
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      req_addr[0]  = $urandom;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_ready_low", 64'(req_ready[0]), 64'd0);
      @(negedge clk);
      check("rst_outs", outs(0), exp_outs(1'b0, 1'b0, 1'b0, 32'h0));
      reset = 1'b0;
      @(negedge clk);
      check("rst_release", outs(0), exp_outs(1'b0, 1'b1, 1'b0, 32'h0));
      txn(0, 1'b0, 32'h1001_000C, 32'h0, 4'hF, 0, 32'h0, 1'b0, "rst_load");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
